// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle for bcd_updown_counter: enable, direction, clear/load
// controls in; packed BCD count, wrap strobe and terminal count out.
interface bcd_updown_counter_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  clr;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  wrap;
    logic                  tc_c;

    modport master (
        output en, up, clr, load, load_val,
        input  count, wrap, tc_c
    );

    modport slave (
        input  en, up, clr, load, load_val,
        output count, wrap, tc_c
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with prescaler, synchronous clear/load,
// optional saturation at the range ends and a one-cycle wrap strobe.
module bcd_updown_counter #(
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned DIV      = 3,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    bcd_updown_counter_if.slave       bus
);
    localparam int unsigned CW = 4 * DIGITS;
    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] p_q,     p_d;
    logic [CW-1:0] count_q, count_d;
    logic          wrap_q,  wrap_d;

    logic [CW-1:0] inc_val;
    logic [CW-1:0] dec_val;
    logic [CW-1:0] clamp_val;
    logic [CW-1:0] nines_val;
    logic          all_nines;
    logic          all_zeros;
    logic          carry;
    logic          borrow;
    logic [3:0]    digit;
    logic [3:0]    ld_digit;
    logic          tick;
    logic          boundary;

    // Per-digit ripple for increment/decrement, load clamping and end detection
    always_comb begin
        inc_val   = '0;
        dec_val   = '0;
        clamp_val = '0;
        nines_val = '0;
        all_nines = 1'b1;
        all_zeros = 1'b1;
        carry     = 1'b1;
        borrow    = 1'b1;
        digit     = 4'd0;
        ld_digit  = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            digit    = count_q[4*i +: 4];
            ld_digit = bus.load_val[4*i +: 4];

            nines_val[4*i +: 4] = 4'd9;
            all_nines = all_nines & (digit == 4'd9);
            all_zeros = all_zeros & (digit == 4'd0);
            clamp_val[4*i +: 4] = (ld_digit > 4'd9) ? 4'd9 : ld_digit;

            if (carry) begin
                if (digit == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end else begin
                inc_val[4*i +: 4] = digit;
            end

            if (borrow) begin
                if (digit == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end else begin
                dec_val[4*i +: 4] = digit;
            end
        end
    end

    assign tick     = bus.en && (p_q == PW'(DIV - 1));
    assign boundary = bus.up ? all_nines : all_zeros;

    // Next state: clear > load > prescaled step > hold
    always_comb begin
        p_d     = p_q;
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.clr) begin
            p_d     = '0;
            count_d = '0;
        end else if (bus.load) begin
            p_d     = '0;
            count_d = clamp_val;
        end else if (tick) begin
            p_d = '0;
            if (boundary) begin
                wrap_d = 1'b1;
                if (!SATURATE) begin
                    count_d = bus.up ? '0 : nines_val;
                end
            end else begin
                count_d = bus.up ? inc_val : dec_val;
            end
        end else if (bus.en) begin
            p_d = p_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q     <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            p_q     <= p_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.tc_c  = boundary;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: wrapping and saturating instances share stimulus,
// an integer-valued model feeds a scoreboard checked after every clock edge.
module tb_bcd_updown_counter;
    localparam int unsigned DIGITS = 2;
    localparam int unsigned DIV    = 3;
    localparam int          MAXV   = 99;
    localparam int unsigned CW     = 4 * DIGITS;

    typedef struct packed {
        logic [CW-1:0] c0;
        logic          w0;
        logic [CW-1:0] c1;
        logic          w1;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          en;
    logic          up;
    logic          clr;
    logic          load;
    logic [CW-1:0] load_val;

    int   n_checks;
    int   n_pass;
    int   m_cnt [2];
    int   m_wrap[2];
    int   m_p;
    exp_t sb_q[$];

    bcd_updown_counter_if #(.DIGITS(DIGITS)) if0 ();
    bcd_updown_counter_if #(.DIGITS(DIGITS)) if1 ();

    assign if0.en = en;   assign if1.en = en;
    assign if0.up = up;   assign if1.up = up;
    assign if0.clr = clr; assign if1.clr = clr;
    assign if0.load = load;         assign if1.load = load;
    assign if0.load_val = load_val; assign if1.load_val = load_val;

    bcd_updown_counter #(.DIGITS(DIGITS), .DIV(DIV), .SATURATE(1'b0)) u_wrap (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    bcd_updown_counter #(.DIGITS(DIGITS), .DIV(DIV), .SATURATE(1'b1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
    endtask

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int            t;
        r = '0;
        t = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int clamp_load(input logic [CW-1:0] lv);
        int v;
        int w;
        int d;
        v = 0;
        w = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * w;
            w = w * 10;
        end
        return v;
    endfunction

    // Reference behaviour for one rising edge, using the currently driven inputs
    task automatic model_step();
        logic tk;
        tk = en && (m_p == int'(DIV) - 1);
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 0;
            if (clr)       m_cnt[k] = 0;
            else if (load) m_cnt[k] = clamp_load(load_val);
            else if (tk) begin
                if (up ? (m_cnt[k] == MAXV) : (m_cnt[k] == 0)) begin
                    m_wrap[k] = 1;
                    if (k == 0) m_cnt[k] = up ? 0 : MAXV;
                end else begin
                    m_cnt[k] = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
                end
            end
        end
        if (clr || load || tk) m_p = 0;
        else if (en)           m_p = m_p + 1;
    endtask

    task automatic model_reset();
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_wrap[0] = 0; m_wrap[1] = 0;
        m_p = 0;
    endtask

    function automatic logic exp_tc(input int v);
        return up ? (v == MAXV) : (v == 0);
    endfunction

    task automatic run_cycle();
        exp_t e;
        model_step();
        e.c0 = to_bcd(m_cnt[0]);
        e.w0 = (m_wrap[0] != 0);
        e.c1 = to_bcd(m_cnt[1]);
        e.w1 = (m_wrap[1] != 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("count_wrapinst", 32'(if0.count), 32'(e.c0));
        check("wrap_wrapinst",  32'(if0.wrap),  32'(e.w0));
        check("count_satinst",  32'(if1.count), 32'(e.c1));
        check("wrap_satinst",   32'(if1.wrap),  32'(e.w1));
        check("tc_wrapinst",    32'(if0.tc_c),  32'(exp_tc(m_cnt[0])));
        check("tc_satinst",     32'(if1.tc_c),  32'(exp_tc(m_cnt[1])));
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        int sat_wraps;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        #12;
        check("reset_count", 32'(if0.count), 32'h0);
        check("reset_wrap",  32'(if0.wrap),  32'h0);
        check("reset_tc",    32'(if0.tc_c),  32'h1);

        @(posedge clk); #1;
        rst = 1'b0; en = 1'b1; up = 1'b1;
        run_n(150);
        check("count_150_clocks", 32'(if0.count), 32'h50);

        load = 1'b1; load_val = 8'h98;
        run_cycle();
        load = 1'b0;
        run_n(3);
        check("load98_to_99", 32'(if0.count), 32'h99);
        check("tc_at_99",     32'(if0.tc_c),  32'h1);
        run_n(3);
        check("wrap_to_00",   32'(if0.count), 32'h00);
        check("wrap_pulse",   32'(if0.wrap),  32'h1);
        run_cycle();
        check("wrap_one_cycle", 32'(if0.wrap), 32'h0);

        load = 1'b1; load_val = 8'h10; up = 1'b0;
        run_cycle();
        load = 1'b0;
        run_n(3);
        check("down_10_to_09", 32'(if0.count), 32'h09);
        load = 1'b1; load_val = 8'h00;
        run_cycle();
        load = 1'b0;
        run_n(3);
        check("down_wrap_99", 32'(if0.count), 32'h99);
        check("down_wrap_pulse", 32'(if0.wrap), 32'h1);
        check("sat_hold_00", 32'(if1.count), 32'h00);

        load = 1'b1; load_val = 8'h99; up = 1'b1;
        run_cycle();
        load = 1'b0;
        sat_wraps = 0;
        for (int i = 0; i < 9; i++) begin
            run_cycle();
            if (if1.wrap) sat_wraps++;
        end
        check("sat_hold_99", 32'(if1.count), 32'h99);
        check("sat_wrap_pulses", 32'(sat_wraps), 32'd3);

        load = 1'b1; load_val = 8'hA7;
        run_cycle();
        check("load_clamp_97", 32'(if0.count), 32'h97);
        clr = 1'b1;
        run_cycle();
        check("clr_beats_load", 32'(if0.count), 32'h00);
        clr = 1'b0; load = 1'b0;
        run_cycle();
        en = 1'b0;
        run_n(10);
        en = 1'b1;
        run_n(2);
        check("en_freeze_resume", 32'(if0.count), 32'h01);

        load = 1'b1; load_val = 8'h42;
        run_cycle();
        load = 1'b0;
        run_cycle();
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", 32'(if0.count), 32'h00);
        check("async_rst_wrap",  32'(if0.wrap),  32'h0);
        #1 rst = 1'b0;
        model_reset();
        run_n(3);
        check("restart_after_rst", 32'(if0.count), 32'h01);

        for (int i = 0; i < 300; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            up       = 1'($urandom_range(0, 1));
            clr      = ($urandom_range(0, 40) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = CW'($urandom);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit BCD up/down counter with a built-in clock prescaler, synchronous load/clear, optional saturation and a wrap strobe. Generalises the board-demo BCD counter to any digit count and either direction. Drives LED or seven-segment display blocks directly from its packed BCD output. Also serves as a reusable timebase or event counter inside larger example designs.

## Interface
- DIGITS, 2: number of BCD digits, ≥1; count range 0 … 10^DIGITS−1.
- DIV, 3: prescaler ratio, ≥1; one count step every DIV enabled clocks (DIV=1 steps every enabled clock).
- SATURATE, 0: 0 = wrap at range ends; 1 = hold at range ends.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  count enable; gates both the prescaler and stepping.
- UP  in  1  direction: 1 = increment, 0 = decrement.
- CLR  in  1  synchronous clear to zero.
- LOAD  in  1  synchronous load of LOAD_VAL.
- LOAD_VAL  in  4*DIGITS  packed BCD preset; digit 0 is bits [3:0].
- COUNT  out  4*DIGITS  registered packed BCD count; digit 0 is bits [3:0].
- WRAP  out  1  registered one-cycle strobe on each boundary step.
- TC  out  1  combinational terminal count: COUNT is all 9s when UP=1, or all 0s when UP=0.

## Operation
- Prescaler: counter P, width max(1, $clog2(DIV)), counts 0 … DIV−1 while EN=1 and holds while EN=0.
- Tick = EN && P == DIV−1; P returns to 0 on a tick.
- Per-edge priority, highest first: RST (async) > CLR > LOAD > tick step > hold.
- CLR: COUNT←0, P←0, WRAP←0.
- LOAD: each digit ← LOAD_VAL digit, with any digit value >9 clamped to 9; P←0; WRAP←0.
- CLR and LOAD together: CLR wins, COUNT←0.
- Up step: digit 0 +1; a digit at 9 becomes 0 and carries into the next digit.
- Down step: digit 0 −1; a digit at 0 becomes 9 and borrows from the next digit.
- Boundary step: a step taken while TC=1 (all 9s going up, or all 0s going down).
  - SATURATE=0: COUNT wraps to all 0s (up) or all 9s (down); WRAP=1 for that cycle.
  - SATURATE=1: COUNT unchanged; WRAP=1 for that cycle, once per blocked tick.
- WRAP=0 on every cycle without a boundary step.
- UP may change on any cycle; the value sampled on the tick edge decides the step direction.
- EN=0: COUNT and P hold. CLR and LOAD still act.

## Timing
- Reset values: COUNT=0, WRAP=0, P=0; TC = (UP==0).
- RST assertion clears COUNT, WRAP and P immediately, without waiting for a clock edge, including in the middle of a prescale period.
- After RST is released, or after CLR/LOAD: first step lands on the DIV-th enabled rising edge.
- COUNT and WRAP update on the tick edge and are visible one cycle after the tick condition is sampled.
- Latency from LOAD/CLR assertion to COUNT: one edge.
- TC follows COUNT and UP combinationally, with zero latency.
- Steady-state throughput with EN held high: exactly one step per DIV clocks.

## Test plan
- DIGITS=2, DIV=3: release RST, then EN=1, UP=1 for 150 clocks -> COUNT=0x50, WRAP never asserted.
- LOAD 0x98, EN=1, UP=1 -> COUNT=0x99 after 3 clocks, TC=1; COUNT=0x00 after 6 clocks, with WRAP high for exactly that one cycle.
- LOAD 0x10, UP=0, 3 clocks -> COUNT=0x09; then LOAD 0x00, 3 clocks -> COUNT=0x99 with a WRAP pulse.
- SATURATE=1: LOAD 0x99, UP=1, 9 clocks -> COUNT stays 0x99; WRAP pulses 3 times, each 1 cycle wide.
- LOAD_VAL=0xA7 -> COUNT=0x97. CLR=1 and LOAD=1 on the same edge -> COUNT=0x00. EN=0 for 10 clocks -> COUNT and P frozen.
- Counting at 0x42, RST pulsed between clock edges -> COUNT=0x00 before the next edge; count restarts and COUNT=0x01 after 3 enabled clocks.
